// File: rtl/gtfwizard_0_example_gtf_common_qpll_ctl.sv
// QPLL0 bring-up controller for GTF_COMMON.
// Sequence: power-down hold, reset hold, lock wait with bounded retries,
// locked monitoring with loss recovery, and a terminal fail state.
// Optional macro GTF_CM_QPLL_LOCK_FILTER_EN qualifies lock in WAIT_LOCK with a
// LOCK_STABLE-cycle consecutive-high filter; loss detection stays unfiltered.
module gtfwizard_0_example_gtf_common_qpll_ctl #(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned RST_CYCLES   = 32,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned LOCK_STABLE  = 64
) (
  input  logic       gtf_cm_drpclk,
  input  logic       gtf_cm_sys_rst,
  input  logic       gtf_cm_qpll_start,
  input  logic       gtf_cm_qpll0lock,
  input  logic       gtf_cm_qpll0refclklost,
  output logic       gtf_cm_qpll0pd,
  output logic       gtf_cm_qpll0reset,
  output logic       gtf_cm_qpll_ready,
  output logic       gtf_cm_qpll_fail,
  output logic [3:0] gtf_cm_qpll_retry_cnt,
  output logic [2:0] gtf_cm_qpll_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PWRDN     = 3'd1,
    RESET     = 3'd2,
    WAIT_LOCK = 3'd3,
    LOCKED    = 3'd4,
    FAIL      = 3'd5
  } state_t;

  if (PD_CYCLES == 0 || RST_CYCLES == 0 || LOCK_TIMEOUT < 2 || MAX_RETRIES > 15) begin : g_param_check
    $error("qpll_ctl: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        lock_meta_q, lock_sync_q;
  logic        lost_meta_q, lost_sync_q;
  logic        pd_q, pd_d;
  logic        rst_q, rst_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        lock_valid;

  // Two-flop synchronizers for the asynchronous GTF_COMMON status pins
  always_ff @(posedge gtf_cm_drpclk) begin
    if (gtf_cm_sys_rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      lost_meta_q <= 1'b0;
      lost_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= gtf_cm_qpll0lock;
      lock_sync_q <= lock_meta_q;
      lost_meta_q <= gtf_cm_qpll0refclklost;
      lost_sync_q <= lost_meta_q;
    end
  end

`ifdef GTF_CM_QPLL_LOCK_FILTER_EN
  logic [31:0] filt_q, filt_d;

  // Consecutive-high lock counter, active only in WAIT_LOCK, saturating at LOCK_STABLE
  always_comb begin
    filt_d = '0;
    if (state_q == WAIT_LOCK && lock_sync_q) begin
      filt_d = (filt_q == LOCK_STABLE) ? filt_q : filt_q + 32'd1;
    end
  end

  // Filter count register
  always_ff @(posedge gtf_cm_drpclk) begin
    if (gtf_cm_sys_rst) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end

  assign lock_valid = lock_sync_q && (filt_q == LOCK_STABLE);
`else
  localparam int unsigned unused_lock_stable = LOCK_STABLE;

  assign lock_valid = lock_sync_q;
`endif

  // Next-state, phase counter and retry bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    retry_d = retry_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gtf_cm_qpll_start) begin
          state_d = PWRDN;
          retry_d = '0;
        end
      end
      PWRDN: begin
        if (cnt_q == PD_CYCLES - 32'd1) begin
          state_d = RESET;
        end
      end
      RESET: begin
        if (cnt_q == RST_CYCLES - 32'd1) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        // Lock wins over a coincident timeout
        if (lock_valid) begin
          state_d = LOCKED;
        end else if (cnt_q == LOCK_TIMEOUT - 32'd1) begin
          if (retry_q < 4'(MAX_RETRIES)) begin
            retry_d = retry_q + 4'd1;
            state_d = RESET;
          end else begin
            state_d = FAIL;
          end
        end
      end
      LOCKED: begin
        cnt_d = '0;
        if (!lock_sync_q || lost_sync_q) begin
          state_d = RESET;
          retry_d = '0;
        end
      end
      FAIL: begin
        cnt_d = '0;
        if (gtf_cm_qpll_start) begin
          state_d = PWRDN;
          retry_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        retry_d = '0;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Output decode from next state so registered outputs track the state register
  always_comb begin
    pd_d    = (state_d == IDLE) || (state_d == PWRDN) || (state_d == FAIL);
    rst_d   = (state_d != WAIT_LOCK) && (state_d != LOCKED);
    ready_d = (state_d == LOCKED);
    fail_d  = (state_d == FAIL);
  end

  // State, counters and registered outputs
  always_ff @(posedge gtf_cm_drpclk) begin
    if (gtf_cm_sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      pd_q    <= 1'b1;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pd_q    <= pd_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
    end
  end

  assign gtf_cm_qpll0pd        = pd_q;
  assign gtf_cm_qpll0reset     = rst_q;
  assign gtf_cm_qpll_ready     = ready_q;
  assign gtf_cm_qpll_fail      = fail_q;
  assign gtf_cm_qpll_retry_cnt = retry_q;
  assign gtf_cm_qpll_state     = state_q;

endmodule

// File: tb/tb_gtfwizard_0_example_gtf_common_qpll_ctl.sv
// Scoreboard bench for the QPLL0 controller: stimulus tasks push the expected
// output transitions (cycle + full output snapshot) derived from sequence
// timing rules; a monitor pops and compares whenever any output changes.
module tb_gtfwizard_0_example_gtf_common_qpll_ctl;

  localparam int unsigned PD = 16;
  localparam int unsigned RS = 32;
  localparam int unsigned TO = 1000;
  localparam int unsigned MR = 3;
  localparam int unsigned LS = 64;
`ifdef GTF_CM_QPLL_LOCK_FILTER_EN
  localparam int EX = LS;
`else
  localparam int EX = 0;
`endif
  // Latest lock-rise offset into WAIT_LOCK that still beats the timeout
  localparam int DMAX = TO - 3 - EX;

  typedef struct packed {
    logic [2:0] st;
    logic       pd;
    logic       rs;
    logic       rdy;
    logic       fl;
    logic [3:0] rc;
  } out_t;

  typedef struct packed {
    int   cyc;
    out_t o;
  } ev_t;

  logic       clk = 1'b0;
  logic       sys_rst, start, lock, lost;
  logic       pd_o, rst_o, rdy_o, fail_o;
  logic [3:0] rc_o;
  logic [2:0] st_o;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lrise = -1000;
  bit   mon_en = 1'b0;
  out_t prev, m_cur;
  ev_t  exp_q[$];

  gtfwizard_0_example_gtf_common_qpll_ctl #(
    .PD_CYCLES   (PD),
    .RST_CYCLES  (RS),
    .LOCK_TIMEOUT(TO),
    .MAX_RETRIES (MR),
    .LOCK_STABLE (LS)
  ) dut (
    .gtf_cm_drpclk         (clk),
    .gtf_cm_sys_rst        (sys_rst),
    .gtf_cm_qpll_start     (start),
    .gtf_cm_qpll0lock      (lock),
    .gtf_cm_qpll0refclklost(lost),
    .gtf_cm_qpll0pd        (pd_o),
    .gtf_cm_qpll0reset     (rst_o),
    .gtf_cm_qpll_ready     (rdy_o),
    .gtf_cm_qpll_fail      (fail_o),
    .gtf_cm_qpll_retry_cnt (rc_o),
    .gtf_cm_qpll_state     (st_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic out_t mk(int st, bit pd, bit rs, bit rdy, bit fl, int rc);
    out_t o;
    o.st  = 3'(st);
    o.pd  = pd;
    o.rs  = rs;
    o.rdy = rdy;
    o.fl  = fl;
    o.rc  = 4'(rc);
    return o;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: any output change must match the head of the expectation queue
  always @(negedge clk) begin
    if (mon_en) begin
      out_t cur;
      ev_t  e;
      cur = {st_o, pd_o, rst_o, rdy_o, fail_o, rc_o};
      if (cur !== prev) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: cyc=%0d got st=%0d pd=%b rst=%b rdy=%b fail=%b rc=%0d, required no change",
                   cyc, cur.st, cur.pd, cur.rs, cur.rdy, cur.fl, cur.rc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.o !== cur) begin
            n_fail++;
            $display("FAIL transition: got cyc=%0d st=%0d pd=%b rst=%b rdy=%b fail=%b rc=%0d, required cyc=%0d st=%0d pd=%b rst=%b rdy=%b fail=%b rc=%0d",
                     cyc, cur.st, cur.pd, cur.rs, cur.rdy, cur.fl, cur.rc,
                     e.cyc, e.o.st, e.o.pd, e.o.rs, e.o.rdy, e.o.fl, e.o.rc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input out_t o);
    ev_t e;
    e.cyc = c;
    e.o   = o;
    exp_q.push_back(e);
    m_cur = o;
  endtask

  task automatic chk(input string nm, input int got, input int req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic set_lock(input bit v);
    if (v && !lock) lrise = cyc;
    lock = v;
  endtask

  task automatic do_rst();
    sys_rst = 1'b1;
    if (m_cur != mk(0, 1, 1, 0, 0, 0)) push(cyc + 1, mk(0, 1, 1, 0, 0, 0));
    tick();
    sys_rst = 1'b0;
  endtask

  // Start pulse sampled at the next edge; returns the cycle WAIT_LOCK is entered
  task automatic do_start(output int w);
    start = 1'b1;
    push(cyc + 1, mk(1, 1, 1, 0, 0, 0));
    push(cyc + 1 + PD, mk(2, 0, 1, 0, 0, 0));
    w = cyc + 1 + PD + RS;
    push(w, mk(3, 0, 0, 0, 0, 0));
    tick();
    start = 1'b0;
  endtask

  // nfail lock windows expire, then lock rises d cycles into the next window
  task automatic run_attempt(input int w0, input int nfail, input int d, output bit ok);
    int w, t, r;
    w = w0;
    r = 0;
    ok = 1'b0;
    if (!lock) begin
      for (int i = 0; i < nfail; i++) begin
        if (r < int'(MR)) begin
          r++;
          push(w + TO, mk(2, 0, 1, 0, 0, r));
          w += TO + RS;
          push(w, mk(3, 0, 0, 0, 0, r));
        end else begin
          push(w + TO, mk(5, 1, 1, 0, 1, r));
          wait_until(w + TO + 2);
          return;
        end
      end
      wait_until(w + d);
      set_lock(1'b1);
    end
    t = imax(w + 1, lrise + 3) + EX;
    push(t, mk(4, 0, 0, 1, 0, r));
    wait_until(t + 2);
    ok = 1'b1;
  endtask

  // One-cycle loss event in LOCKED (lock dip or refclklost pulse), optional start held high
  task automatic do_loss(input bit kind, input bit hold_start);
    int d0, w, t;
    if (hold_start) start = 1'b1;
    repeat ($urandom_range(1, 5)) tick();
    d0 = cyc;
    w  = d0 + 3 + RS;
    push(d0 + 3, mk(2, 0, 1, 0, 0, 0));
    push(w, mk(3, 0, 0, 0, 0, 0));
    if (kind) lost = 1'b1;
    else      set_lock(1'b0);
    tick();
    lost = 1'b0;
    set_lock(1'b1);
    t = imax(w + 1, lrise + 3) + EX;
    push(t, mk(4, 0, 0, 1, 0, 0));
    wait_until(t + 2);
    start = 1'b0;
    wait_until(t + 4);
  endtask

  initial begin
    int  w;
    bit  ok;
    sys_rst = 1'b1;
    start   = 1'b0;
    lock    = 1'b0;
    lost    = 1'b0;
    repeat (3) tick();
    chk("reset_state", int'(st_o), 0);
    chk("reset_pd", int'(pd_o), 1);
    chk("reset_qrst", int'(rst_o), 1);
    chk("reset_ready", int'(rdy_o), 0);
    chk("reset_fail", int'(fail_o), 0);
    chk("reset_retry", int'(rc_o), 0);
    prev    = mk(0, 1, 1, 0, 0, 0);
    m_cur   = prev;
    sys_rst = 1'b0;
    mon_en  = 1'b1;
    repeat (4) tick();

    // Nominal bring-up, lock 100 cycles into WAIT_LOCK, then both loss kinds
    do_start(w);
    run_attempt(w, 0, 100, ok);
    do_loss(1'b0, 1'b0);
    do_loss(1'b1, 1'b1);

    // Exhaust retries into FAIL, restart from FAIL, lock and timeout coincide
    do_rst();
    set_lock(1'b0);
    do_start(w);
    run_attempt(w, 4, 0, ok);
    repeat (5) tick();
    do_start(w);
    run_attempt(w, 0, DMAX, ok);

    // Lock arrives in the final permitted window
    do_rst();
    set_lock(1'b0);
    do_start(w);
    run_attempt(w, int'(MR), int'($urandom_range(0, DMAX)), ok);

    // Synchronous reset mid WAIT_LOCK with a retry already consumed
    do_rst();
    set_lock(1'b0);
    do_start(w);
    push(w + TO, mk(2, 0, 1, 0, 0, 1));
    push(w + TO + RS, mk(3, 0, 0, 0, 0, 1));
    wait_until(w + TO + RS + 499);
    do_rst();

    // Randomized sequences
    repeat (4) begin
      bit pre_lock;
      pre_lock = 1'($urandom_range(0, 1));
      set_lock(pre_lock);
      repeat ($urandom_range(0, 20)) tick();
      do_start(w);
      run_attempt(w, pre_lock ? 0 : int'($urandom_range(0, MR + 1)),
                  int'($urandom_range(0, DMAX)), ok);
      if (ok) begin
        repeat ($urandom_range(0, 2)) do_loss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      do_rst();
    end

    repeat (20) tick();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding, required 0 (next cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gtfwizard_0_example_gtf_common_qpll_ctl.md
GTFWIZARD_0_EXAMPLE_GTF_COMMON_QPLL_CTL -- requirements
Module: gtfwizard_0_example_gtf_common_qpll_ctl

Interface
REQ-001 Parameter PD_CYCLES, default 16: cycles QPLL0 is held powered down before reset release.
REQ-002 Parameter RST_CYCLES, default 32: cycles QPLL0 reset is held after power-up.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: WAIT_LOCK cycles before a retry, range 2 to 2^32-1.
REQ-004 Parameter MAX_RETRIES, default 3: retries before FAIL, range 0 to 15.
REQ-005 Parameter LOCK_STABLE, default 64: filter length; used only with the macro in REQ-030.
REQ-006 gtf_cm_drpclk  in  1  sole clock; all logic on its rising edge.
REQ-007 gtf_cm_sys_rst  in  1  reset, synchronous, active-high.
REQ-008 gtf_cm_qpll_start  in  1  start/restart request, sampled each cycle.
REQ-009 gtf_cm_qpll0lock  in  1  QPLL0LOCK from GTF_COMMON, asynchronous.
REQ-010 gtf_cm_qpll0refclklost  in  1  QPLL0REFCLKLOST from GTF_COMMON, asynchronous.
REQ-011 gtf_cm_qpll0pd  out  1  drives QPLL0PD.
REQ-012 gtf_cm_qpll0reset  out  1  drives QPLL0RESET.
REQ-013 gtf_cm_qpll_ready  out  1  high only in LOCKED.
REQ-014 gtf_cm_qpll_fail  out  1  high only in FAIL.
REQ-015 gtf_cm_qpll_retry_cnt  out  4  retries used in the current sequence.
REQ-016 gtf_cm_qpll_state  out  3  current state encoding.

Function
REQ-017 Lock and refclklost SHALL each pass a 2-flop synchronizer; all decisions use synchronized values.
REQ-018 States SHALL be IDLE=0, PWRDN=1, RESET=2, WAIT_LOCK=3, LOCKED=4, FAIL=5; all outputs registered and decoded from next state.
REQ-019 IDLE: pd=1, reset=1; start=1 -> PWRDN, retry_cnt cleared.
REQ-020 PWRDN: pd=1, reset=1 for exactly PD_CYCLES cycles -> RESET.
REQ-021 RESET: pd=0, reset=1 for exactly RST_CYCLES cycles -> WAIT_LOCK.
REQ-022 WAIT_LOCK: pd=0, reset=0; 32-bit timer runs; lock valid -> LOCKED; lock valid and timeout in the same cycle -> LOCKED.
REQ-023 Timeout (timer = LOCK_TIMEOUT-1): retry_cnt < MAX_RETRIES -> retry_cnt+1, RESET; otherwise -> FAIL.
REQ-024 LOCKED: pd=0, reset=0, ready=1; synchronized lock low or refclklost high -> RESET, retry_cnt cleared, ready low the same cycle.
REQ-025 FAIL: pd=1, reset=1, fail=1, retry_cnt held; start=1 -> PWRDN, retry_cnt cleared, fail low.
REQ-026 start SHALL be ignored in PWRDN, RESET, WAIT_LOCK and LOCKED; loss events in LOCKED take effect regardless of start.
REQ-027 Without filter, ready SHALL rise 3 cycles after the lock pin rises (2 sync + 1 state register).
REQ-028 Phase counters SHALL clear on every state entry; retry_cnt SHALL never exceed MAX_RETRIES.

Reset
REQ-029 On gtf_cm_sys_rst=1 at a clock edge: state IDLE, pd=1, reset=1, ready=0, fail=0, retry_cnt=0, all counters and synchronizers 0; applies mid-sequence and overrides all other inputs.

Configuration
REQ-030 Macro GTF_CM_QPLL_LOCK_FILTER_EN defined: lock is valid in WAIT_LOCK only after LOCK_STABLE consecutive synchronized-high cycles; the filter count clears on any low; ready latency = LOCK_STABLE+3 cycles; loss detection in LOCKED stays unfiltered.
REQ-031 Macro not defined: synchronized lock is used directly, no filter logic present, and LOCK_STABLE has no effect.

Verification (PD_CYCLES=16, RST_CYCLES=32, LOCK_TIMEOUT=1000, MAX_RETRIES=3, LOCK_STABLE=64)
REQ-032 Reset, start pulse, lock raised 100 cycles into WAIT_LOCK -> pd falls 16 cycles after start, reset falls 32 cycles later, ready rises 3 cycles after lock (macro off).
REQ-033 Lock never rises -> retry_cnt steps 1,2,3 at 1032-cycle intervals; then FAIL with fail=1, pd=1, reset=1; start -> PWRDN, retry_cnt=0, fail=0.
REQ-034 In LOCKED, lock low for 1 cycle -> ready low 3 cycles later, state=RESET, reset high 32 cycles, relock -> ready.
REQ-035 In LOCKED, 1-cycle refclklost pulse -> same response as REQ-034; start held high in LOCKED -> no effect.
REQ-036 sys_rst at WAIT_LOCK cycle 500 -> next edge IDLE, pd=1, reset=1, ready=0, retry_cnt=0.
REQ-037 Macro on, lock toggling 10 high / 1 low -> ready stays 0 until timeout; lock steady high -> ready 67 cycles after the rising edge.
